// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO; whole packets are presented only after tlast is stored.
// Latency: first beat is valid the cycle after its packet's last beat is written, then one beat per cycle.
// Backpressure: s_tready drops while full; a partial packet that fills storage cuts through to avoid deadlock.
module axis_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [ADDR_W:0]   fill_level,
  output logic [ADDR_W:0]   pkt_count,
  output logic              oversize
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  // Each entry holds {last, data}.
  logic [DATA_W:0] mem_q [DEPTH];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] fill_q, fill_d;
  logic [ADDR_W:0] pkt_count_q, pkt_count_d;
  logic            release_q, release_d;
  logic            oversize_q, oversize_d;

  logic            empty, full;
  logic            wr_en, rd_en, wr_last, rd_last;
  logic [DATA_W:0] head;

  // Status decode, handshakes and first-word fall-through output view.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    head       = mem_q[rd_ptr_q[ADDR_W-1:0]];
    s_tready   = reset_n && !full;
    // A stored partial packet is only exposed once release has been granted.
    m_tvalid   = !empty && ((pkt_count_q != '0) || release_q);
    m_tdata    = empty ? '0 : head[DATA_W-1:0];
    m_tlast    = !empty && head[DATA_W];
    wr_en      = s_tvalid && s_tready;
    rd_en      = m_tvalid && m_tready;
    wr_last    = wr_en && s_tlast;
    rd_last    = rd_en && head[DATA_W];
    fill_level = fill_q;
    pkt_count  = pkt_count_q;
    oversize   = oversize_q;
  end

  // Next-state for pointers, occupancy counters and the cut-through release.
  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + ONE : rd_ptr_q;

    fill_d      = fill_q;
    if (wr_en && !rd_en) begin
      fill_d = fill_q + ONE;
    end else if (!wr_en && rd_en) begin
      fill_d = fill_q - ONE;
    end

    pkt_count_d = pkt_count_q;
    if (wr_last && !rd_last) begin
      pkt_count_d = pkt_count_q + ONE;
    end else if (!wr_last && rd_last) begin
      pkt_count_d = pkt_count_q - ONE;
    end

    // Full with no complete packet means the packet is longer than storage:
    // stream it out as it arrives until its last beat leaves.
    release_d  = release_q;
    oversize_d = oversize_q;
    if (full && (pkt_count_q == '0)) begin
      release_d  = 1'b1;
      oversize_d = 1'b1;
    end
    if (rd_last) begin
      release_d = 1'b0;
    end
  end

  // Control state; reset discards everything, including any half-sent packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      pkt_count_q <= '0;
      release_q   <= 1'b0;
      oversize_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      pkt_count_q <= pkt_count_d;
      release_q   <= release_d;
      oversize_q  <= oversize_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast, s_tdata};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: randomized and directed packets against a queue-based packet model.
// Inputs change 1ns after the rising edge; beats are observed on the falling edge.
// Status outputs are compared 3ns after every rising edge.
module tb_axis_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [ADDR_W:0]   fill_level;
  logic [ADDR_W:0]   pkt_count;
  logic              oversize;

  axis_pkt_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .fill_level (fill_level),
    .pkt_count  (pkt_count),
    .oversize   (oversize)
  );

  always #5 clk = ~clk;

  // Model: every accepted beat {last,data} in arrival order, not yet read out.
  logic [8:0] exp_q[$];
  bit         rel_m;
  bit         ovs_m;
  int         tests;
  int         fails;
  bit         hold_prev;
  logic [8:0] hold_dat;
  bit         done_w;

  function automatic int lasts();
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i][8]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    rel_m = 1'b0;
    ovs_m = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left 1ns after a rising edge; the beat is recorded once accepted.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        exp_q.push_back({l, d});
        break;
      end
      n++;
      if (n > 300) begin
        timeout_fail("send_beat");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
    m_tready = 1'b0;
  endtask

  // Status checker: occupancy, packet count, valid gating and sticky oversize.
  initial forever begin
    @(posedge clk);
    #3;
    chk("fill_level", int'(fill_level), exp_q.size());
    chk("pkt_count", int'(pkt_count), lasts());
    chk("m_tvalid", int'(m_tvalid), int'(exp_q.size() > 0 && (lasts() > 0 || rel_m)));
    chk("oversize", int'(oversize), int'(ovs_m));
    // A storage-sized run with no tlast forces cut-through from the next edge.
    if (exp_q.size() == DEPTH && lasts() == 0) begin
      rel_m = 1'b1;
      ovs_m = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each transfer and checks stall stability.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", int'(m_tvalid), 1);
        chk("stall_beat", int'({m_tlast, m_tdata}), int'(hold_dat));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: actual=%0h required=none at %0t", {m_tlast, m_tdata}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat", int'({m_tlast, m_tdata}), int'(e));
          if (e[8]) rel_m = 1'b0;
        end
      end
      hold_prev = m_tvalid && !m_tready;
      hold_dat  = {m_tlast, m_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    tests    = 0;
    fails    = 0;
    done_w   = 1'b0;
    model_reset();

    // Reset held for 3 cycles.
    #1 reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("reset_s_tready", int'(s_tready), 0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #2;
    chk("post_reset_s_tready", int'(s_tready), 1);
    @(posedge clk);
    #1;

    // Single packet, consumer stalled until the packet is complete.
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    #2 chk("partial_valid", int'(m_tvalid), 0);
    @(posedge clk);
    #1;
    send_beat(8'h44, 1'b1);
    #2;
    chk("pkt_valid", int'(m_tvalid), 1);
    chk("pkt_count_1", int'(pkt_count), 1);
    chk("fill_4", int'(fill_level), 4);
    @(posedge clk);
    #1 m_tready = 1'b1;
    cyc(4);
    #2 chk("burst_fill_0", int'(fill_level), 0);
    m_tready = 1'b0;
    @(posedge clk);
    #1;

    // Full, held-off 17th beat, partial read, then wrap.
    for (int i = 1; i <= 16; i++) send_beat(8'(i * 7 + 3), i == 16);
    #2;
    chk("full_s_tready", int'(s_tready), 0);
    chk("full_fill", int'(fill_level), 16);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 17; i <= 24; i++) send_beat(8'(i * 7 + 3), i == 24);
      end
      begin
        cyc(3);
        #2;
        chk("held_off_fill", int'(fill_level), 16);
        chk("held_off_ready", int'(s_tready), 0);
        @(posedge clk);
        #1 m_tready = 1'b1;
        cyc(8);
        m_tready = 1'b0;
      end
    join
    drain();

    // Simultaneous last-beat write and last-beat read with two packets stored.
    send_beat(8'hA1, 1'b1);
    send_beat(8'hA2, 1'b1);
    m_tready = 1'b1;
    send_beat(8'hA3, 1'b1);
    m_tready = 1'b0;
    #2;
    chk("simul_pkt_count", int'(pkt_count), 2);
    chk("simul_fill", int'(fill_level), 2);
    @(posedge clk);
    #1;
    drain();

    // Randomized packets against a randomly stalling consumer.
    done_w = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) send_beat(8'($urandom), b == len - 1);
          cyc($urandom_range(0, 2));
        end
        done_w = 1'b1;
      end
      begin
        int n = 0;
        while (!(done_w && exp_q.size() == 0) && n < 5000) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          n++;
        end
        if (!(done_w && exp_q.size() == 0)) timeout_fail("random_drain");
        m_tready = 1'b0;
      end
    join

    // Oversize packet: 20 beats with no tlast, then the terminating beat.
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(8'(8'h80 + i), 1'b0);
        send_beat(8'hEE, 1'b1);
      end
      begin
        int n = 0;
        while (fill_level != 5'd16 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (fill_level != 5'd16) timeout_fail("oversize_fill");
        @(posedge clk);
        #3;
        chk("oversize_flag", int'(oversize), 1);
        chk("oversize_valid", int'(m_tvalid), 1);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();

    // Release must be gone: a lone non-last beat stays hidden.
    send_beat(8'h5A, 1'b0);
    cyc(2);
    #2;
    chk("release_cleared", int'(m_tvalid), 0);
    chk("oversize_sticky", int'(oversize), 1);
    @(posedge clk);
    #1;
    send_beat(8'h5B, 1'b1);
    drain();

    // Reset mid-packet discards the partial packet.
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    reset_n = 1'b0;
    model_reset();
    cyc(1);
    reset_n = 1'b1;
    #2;
    chk("midrst_fill", int'(fill_level), 0);
    chk("midrst_pkt", int'(pkt_count), 0);
    chk("midrst_oversize", int'(oversize), 0);
    @(posedge clk);
    #1;
    cyc(3);
    send_beat(8'hD1, 1'b0);
    send_beat(8'hD2, 1'b1);
    drain();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Store-and-forward packet FIFO for the 8-bit AXI-Stream datapath. It sits directly downstream of the two-input stream mux and absorbs its output beats, including `tlast`. It presents whole packets to the next consumer only once the final beat has been stored. This decouples the mux from consumer stalls and keeps a packet contiguous on the output.

## Interface
Parameters:
- `DATA_W`, 8, payload width in bits.
- `ADDR_W`, 4, log2 of storage depth; DEPTH = 2**ADDR_W entries (default 16).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous assert, active-low reset.
- `s_tdata`  input  DATA_W  input beat data.
- `s_tvalid`  input  1  input beat valid.
- `s_tlast`  input  1  input beat ends a packet.
- `s_tready`  output  1  FIFO can accept a beat.
- `m_tdata`  output  DATA_W  output beat data.
- `m_tvalid`  output  1  output beat valid.
- `m_tlast`  output  1  output beat ends a packet.
- `m_tready`  input  1  consumer accepts the beat.
- `fill_level`  output  ADDR_W+1  number of stored beats, 0..DEPTH.
- `pkt_count`  output  ADDR_W+1  number of complete packets stored.
- `oversize`  output  1  sticky flag: a packet overflowed the storage before its `tlast` arrived.

## Operation
- Storage: DEPTH x (DATA_W+1) array holding data plus last bit.
- Pointers: write and read pointers are each ADDR_W+1 bits wide.
  - Storage is addressed by the low ADDR_W bits.
  - The MSB disambiguates full from empty.
  - Pointers wrap naturally modulo 2*DEPTH.
- Empty and full:
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) and (MSBs differ).
- `s_tready` = !full. It is forced to 0 while `reset_n` is low.
- Write: on an edge with `s_tvalid && s_tready`, store {`s_tlast`, `s_tdata`} at wr_ptr and increment wr_ptr.
- Read: on an edge with `m_tvalid && m_tready`, increment rd_ptr.
- `m_tdata` and `m_tlast` are the entry at rd_ptr (first-word fall-through). They are don't-care when `m_tvalid`=0.
- `pkt_count` update per edge:
  - +1 on a write whose beat has last=1.
  - −1 on a read whose beat has last=1.
  - Both in the same cycle: unchanged.
- `fill_level` update per edge:
  - +1 on a write only.
  - −1 on a read only.
  - Unchanged on both or neither.
- `m_tvalid` = !empty && (pkt_count != 0 || release).
- `release` register (oversize cut-through):
  - Set when full && pkt_count == 0. The storage is then holding a partial packet longer than DEPTH, and the output must drain to avoid deadlock.
  - While set, beats stream out as they arrive.
  - Cleared on the edge that reads a beat with last=1.
- `oversize` sets together with `release` and stays set until reset.
- Reset mid-packet: all state is cleared immediately. Any stored or partial packet is discarded. There is no recovery of a half-sent packet.

## Timing
- Reset values:
  - wr_ptr = rd_ptr = 0.
  - `fill_level` = 0, `pkt_count` = 0.
  - `release` = 0, `oversize` = 0.
  - `m_tvalid` = 0, `s_tready` = 0 during reset, 1 after deassertion.
  - `m_tdata` and `m_tlast` are driven 0 while empty.
- Store-and-forward latency: if a packet's last beat is written at edge N, its first beat shows `m_tvalid`=1 during the cycle after edge N.
- Burst rate: with `m_tready` held high, one beat per cycle; the packet streams contiguously with no bubbles.
- Full:
  - `s_tready` drops in the cycle after the edge that fills the last entry.
  - A simultaneous read and write when full is impossible, because `s_tready`=0.
  - A read when full re-raises `s_tready` the next cycle.
- Empty: `m_tvalid`=0. A write into an empty FIFO without last does not raise `m_tvalid` unless `release`=1.
- Handshake rules:
  - `m_tvalid`, `m_tdata` and `m_tlast` are stable while `m_tvalid && !m_tready`.
  - `m_tvalid` never deasserts without a transfer, except on reset.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release.
  - Required: `m_tvalid`=0, `fill_level`=0, `pkt_count`=0 and `oversize`=0.
  - `s_tready`=0 during reset and 1 on the first cycle after release.
- Single packet: write 4 beats 0x11,0x22,0x33,0x44 (last on 0x44) with `m_tready`=0.
  - During the packet: `m_tvalid` stays 0 until the 0x44 write edge, then 1; `pkt_count`=1, `fill_level`=4.
  - Then raise `m_tready`: 0x11..0x44 are read on 4 consecutive cycles with `m_tlast` only on 0x44, ending with `fill_level`=0.
- Full and wrap: write 16 beats (last on beat 16) with the consumer stalled.
  - `s_tready`=0 after the 16th write; a 17th beat must be held off.
  - Read 8 beats, then write 8 more with pointer wrap.
  - All 24 beats emerge in order with correct last bits.
- Simultaneous read and write: with 2 complete packets stored, write a last beat while reading a last beat in the same cycle. Required: `pkt_count` stays 2 and `fill_level` is unchanged.
- Oversize: send 20 beats without `tlast` into the 16-entry FIFO.
  - `oversize`=1 and `m_tvalid`=1 once full.
  - All 20 beats plus the terminating last beat drain in order.
  - `release` clears after the last beat is read.
- Reset mid-packet: after writing 3 beats of a packet, pulse `reset_n` low for 1 cycle. Required: `fill_level`=0, `pkt_count`=0, and no stale beat appears afterward.
